hamming_rx_serializer: RTL and testbench

Receive-side output stage of the transceiver. It accepts 12-bit Hamming(12,8) codewords from the demodulator/decoder path and performs syndrome decode with single-bit correction. It buffers one word and shifts the recovered byte out serially on `q`, pulsing `done` with the last bit. It is the consumer of the 12-bit codeword stream and the producer of the `q`/`done` pair at the top level.

---
 rtl/hamming_rx_serializer.sv | 151 +++++++++++++++
 tb/tb_hamming_rx_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_rx_serializer.sv
// hamming_rx_serializer
// Receive-side output stage: buffers one Hamming(12,8) codeword, corrects a
// single-bit error when the word is loaded, and shifts the recovered byte
// out MSB first on q. done marks the cycle that carries bit 0.
//
// Optional feature macro: HAMMING_ERR_CNT_EN adds the saturating error
// counters corr_cnt / uncorr_cnt.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | shifter empty, q=0; loads as soon as the buffer is full and en=1
// S_SHIFT | byte in flight, q=shreg[MSB]; done on the cnt==last cycle

module hamming_rx_serializer #(
  parameter int DATA_W = 8,
  parameter int CODE_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              q,
  output logic              done,
  output logic              busy,
  output logic              corrected,
  output logic              uncorrectable
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       uncorr_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  logic              buf_full;
  logic [CODE_W-1:0] buf_code;
  logic [3:0]        buf_syn;

  logic              accept;
  logic              load;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] load_data;
  logic              syn_corr;
  logic              syn_unc;

  // Syndrome bit k covers every position (1-based) whose index has bit k set.
  function automatic logic [3:0] syndrome(input logic [CODE_W-1:0] c);
    logic [3:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8]  ^ c[10];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9]  ^ c[10];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11];
    s[3] = c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
    return s;
  endfunction

  assign code_ready = !buf_full;
  assign accept     = code_valid && code_ready;

  // A load happens from IDLE, or back-to-back on the final bit of a byte.
  assign load = en && buf_full && ((state == S_IDLE) || (cnt == CNT_LAST));

  assign syn_corr = (buf_syn != 4'd0) && (buf_syn <= 4'd12);
  assign syn_unc  = (buf_syn >= 4'd13);

  // Flip the addressed position for correctable syndromes, then extract data.
  always_comb begin
    fixed_code = buf_code;
    if (syn_corr) begin
      fixed_code[buf_syn - 4'd1] = ~buf_code[buf_syn - 4'd1];
    end
    load_data = {fixed_code[11], fixed_code[10], fixed_code[9], fixed_code[8],
                 fixed_code[6],  fixed_code[5],  fixed_code[4], fixed_code[2]};
  end

  // One-word input buffer; the syndrome is computed once, at accept time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full <= 1'b0;
      buf_code <= '0;
      buf_syn  <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_code <= code_in;
      buf_syn  <= syndrome(code_in);
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Shifter FSM with registered error-flag pulses (valid alongside d7).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      shreg         <= '0;
      cnt           <= '0;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
    end else begin
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      if (load) begin
        state         <= S_SHIFT;
        shreg         <= load_data;
        cnt           <= '0;
        corrected     <= syn_corr;
        uncorrectable <= syn_unc;
      end else if ((state == S_SHIFT) && en) begin
        shreg <= {shreg[DATA_W-2:0], 1'b0};
        cnt   <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state <= S_IDLE;
        end
      end
    end
  end

  assign busy = (state == S_SHIFT);
  assign q    = busy && shreg[DATA_W-1];
  assign done = busy && (cnt == CNT_LAST);

`ifdef HAMMING_ERR_CNT_EN
  // Saturating error counters, bumped on the load edge that raises each flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (load) begin
      if (syn_corr && (corr_cnt != 16'hFFFF)) begin
        corr_cnt <= corr_cnt + 16'd1;
      end
      if (syn_unc && (uncorr_cnt != 16'hFFFF)) begin
        uncorr_cnt <= uncorr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hamming_rx_serializer.sv
// Scoreboard bench for hamming_rx_serializer: stimulus pushes the expected
// byte and flags per accepted word; a monitor rebuilds bytes from q.
module tb_hamming_rx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] code_in;
  logic        code_valid;
  logic        code_ready;
  logic        q;
  logic        done;
  logic        busy;
  logic        corrected;
  logic        uncorrectable;
`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  hamming_rx_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .code_in       (code_in),
    .code_valid    (code_valid),
    .code_ready    (code_ready),
    .q             (q),
    .done          (done),
    .busy          (busy),
    .corrected     (corrected),
    .uncorrectable (uncorrectable)
`ifdef HAMMING_ERR_CNT_EN
    ,
    .corr_cnt      (corr_cnt),
    .uncorr_cnt    (uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       fc;
    logic       fu;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         mon_bitn = 0;
  logic [7:0] mon_acc  = '0;
  int         mon_nc   = 0;
  int         mon_nu   = 0;
  int         done_cnt = 0;

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6]  = d[3];
    c[8] = d[4]; c[9] = d[5]; c[10] = d[6]; c[11] = d[7];
    c[0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3] = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7] = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a bit is consumed on every edge where busy && en.
  always @(negedge clk) begin
    if (!rst) begin
      mon_bitn = 0;
      mon_acc  = '0;
      mon_nc   = 0;
      mon_nu   = 0;
    end else begin
      if (corrected)     mon_nc++;
      if (uncorrectable) mon_nu++;
      if (busy && en) begin
        mon_acc = {mon_acc[6:0], q};
        check("done_position", {31'd0, done}, {31'd0, (mon_bitn == 7)});
        if (mon_bitn == 7) begin
          done_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h, expected none", mon_acc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("byte", {24'd0, mon_acc}, {24'd0, e.data});
            check("corrected_pulses", mon_nc, {31'd0, e.fc});
            check("uncorrectable_pulses", mon_nu, {31'd0, e.fu});
          end
          mon_bitn = 0;
          mon_nc   = 0;
          mon_nu   = 0;
        end else begin
          mon_bitn++;
        end
      end
    end
  end

  task automatic send(input logic [11:0] c, input logic [7:0] d, input logic fc, input logic fu);
    int t;
    exp_t e;
    t = 0;
    while (!code_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!code_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      e.data = d; e.fc = fc; e.fu = fu;
      sb.push_back(e);
      code_in    = c;
      code_valid = 1'b1;
      @(posedge clk); #1;
      code_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while ((sb.size() != 0 || busy) && t < 1000);
    check("drain_queue_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic [11:0] c;
    logic        qh;
    int          t;
    int          dbase;

    rst = 1'b0; en = 1'b0; code_in = '0; code_valid = 1'b0;

    // Reset hold with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      code_in    = 12'($urandom);
      code_valid = 1'($urandom);
      en         = 1'($urandom);
      @(negedge clk);
      check("reset_outputs", {27'd0, q, done, busy, corrected, uncorrectable}, 32'd0);
      check("reset_code_ready", {31'd0, code_ready}, 32'd1);
    end
    @(posedge clk); #1;
    code_valid = 1'b0;
    en         = 1'b1;
    rst        = 1'b1;

    // Clean word A5 (hand-computed codeword) with latency checks.
    send(12'hA27, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_idle_busy", {31'd0, busy}, 32'd0);
    check("lat_ready_low", {31'd0, code_ready}, 32'd0);
    @(negedge clk);
    check("lat_first_bit", {29'd0, busy, q, code_ready}, 32'b111);
    drain();

    // 8'h3C with every position 1..12 flipped.
    for (int p = 0; p < 12; p++) begin
      c = encode(8'h3C);
      c[p] = ~c[p];
      send(c, 8'h3C, 1'b1, 1'b0);
    end
    drain();

    // Syndrome 14 (positions 6 and 8 flipped) -> raw data with d2 flipped.
    c = encode(8'h5A) ^ 12'h0A0;
    send(c, 8'h5E, 1'b0, 1'b1);
    drain();
`ifdef HAMMING_ERR_CNT_EN
    check("corr_cnt", {16'd0, corr_cnt}, 32'd12);
    check("uncorr_cnt", {16'd0, uncorr_cnt}, 32'd1);
`endif

    // Back-to-back 01 then 80 with a 3-cycle stall mid first byte.
    dbase = done_cnt;
    send(encode(8'h01), 8'h01, 1'b0, 1'b0);
    send(encode(8'h80), 8'h80, 1'b0, 1'b0);
    en = 1'b0;
    qh = q;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_frozen", {29'd0, q, busy, done}, {29'd0, qh, 1'b1, 1'b0});
    end
    en = 1'b1;
    t = 0;
    while (done_cnt < dbase + 1 && t < 100) begin @(negedge clk); #1; t++; end
    check("b2b_first_done", done_cnt - dbase, 32'd1);
    @(negedge clk);
    check("b2b_no_gap", {31'd0, busy}, 32'd1);
    t = 0;
    while (done_cnt < dbase + 2 && t < 100) begin @(negedge clk); #1; t++; end
    check("b2b_done_twice", done_cnt - dbase, 32'd2);
    drain();

    // Reset mid-shift with a word waiting in the buffer.
    send(encode(8'hC3), 8'hC3, 1'b0, 1'b0);
    send(encode(8'h77), 8'h77, 1'b0, 1'b0);
    t = 0;
    while (mon_bitn != 4 && t < 100) begin @(negedge clk); #1; t++; end
    check("mid_reached_bit4", mon_bitn, 32'd4);
    #1;
    rst = 1'b0;
    #1;
    check("mid_reset_outputs", {29'd0, q, busy, done}, 32'd0);
    check("mid_reset_ready", {31'd0, code_ready}, 32'd1);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    send(encode(8'hE1), 8'hE1, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
